// File: rtl/approx_add_pkg.sv
// approx_add_pkg -- shared constants for the approximate adder pipeline.
//   MODE_EXACT / MODE_APPROX : encodings of the MODE operand flag
//   ERR_SUM_W / ERR_CNT_W    : widths of the error-statistic accumulators
//   ERR_SUM_SAT / ERR_CNT_SAT: saturation ceilings of those accumulators
package approx_add_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    localparam int ERR_SUM_W = 32;
    localparam int ERR_CNT_W = 16;

    localparam logic [ERR_SUM_W-1:0] ERR_SUM_SAT = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = '1;

endpackage

// File: rtl/approx_add_core.sv
// approx_add_core -- combinational exact / lower-part-OR approximate adder.
//   a, b  : W-bit operands
//   mode  : MODE_EXACT -> a + b, MODE_APPROX -> low K bits ORed, upper part
//           added with a carry guessed from bit K-1 of both operands
//   sum   : W+1-bit result, MSB is carry-out
// K = 0 degenerates to an exact adder in both modes.
module approx_add_core
    import approx_add_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W:0]   sum
);

    logic [W:0] exact_sum;
    logic [W:0] approx_sum;

    assign exact_sum = {1'b0, a} + {1'b0, b};

    generate
        if (K == 0) begin : g_exact_only
            assign approx_sum = exact_sum;
        end else begin : g_approx
            // Carry into the upper part is predicted from the top low bit
            // only, so no carry chain crosses the K boundary.
            logic c;
            assign c = a[K-1] & b[K-1];
            assign approx_sum[K-1:0] = a[K-1:0] | b[K-1:0];
            if (K == W) begin : g_no_upper
                assign approx_sum[W] = c;
            end else begin : g_upper
                assign approx_sum[W:K] = {1'b0, a[W-1:K]} + {1'b0, b[W-1:K]}
                                       + {{(W-K){1'b0}}, c};
            end
        end
    endgenerate

    assign sum = (mode == MODE_APPROX) ? approx_sum : exact_sum;

endmodule

// File: rtl/approx_add_pipe.sv
// approx_add_pipe -- 2-stage valid/ready pipeline around approx_add_core,
// with an optional error monitor comparing each result against the exact sum.
//   CLK, RST          : clock, synchronous active-high reset
//   IN_VALID/IN_READY : operand handshake (A, B, MODE)
//   OUT_VALID/OUT_READY, O : result handshake, O is W+1 bits
//   ERR_CLR           : zero the statistics (wins over a same-cycle result)
//   ERR_SUM/ERR_MAX/ERR_CNT : accumulated / largest / nonzero-count of |O-(A+B)|
// Macro APPROX_ERR_MON_EN builds the monitor; when undefined the statistic
// ports are tied to 0 and ERR_CLR is ignored.
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [W-1:0]         A,
    input  logic [W-1:0]         B,
    input  logic                 MODE,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [W:0]           O,
    input  logic                 ERR_CLR,
    output logic [ERR_SUM_W-1:0] ERR_SUM,
    output logic [W:0]           ERR_MAX,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         mode;
    } s1_t;

    logic [2:1] vld_pipe;
    s1_t        s1_q;
    logic [W:0] o_q;
    logic [W:0] core_sum;
    logic       s1_adv;
    logic       s2_adv;

    assign s2_adv    = !vld_pipe[2] || OUT_READY;
    assign s1_adv    = s2_adv || !vld_pipe[1];
    // Gated by RST so nothing is offered as accepted during reset.
    assign IN_READY  = s1_adv && !RST;
    assign OUT_VALID = vld_pipe[2];
    assign O         = o_q;

    approx_add_core #(.W(W), .K(K)) u_core (
        .a    (s1_q.a),
        .b    (s1_q.b),
        .mode (s1_q.mode),
        .sum  (core_sum)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            o_q      <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= IN_VALID;
                if (IN_VALID)
                    s1_q <= '{a: A, b: B, mode: MODE};
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1])
                    o_q <= core_sum;
            end
        end
    end

`ifdef APPROX_ERR_MON_EN
    logic [W:0]           exact_q;
    logic [W:0]           err;
    logic                 out_hs;
    logic [ERR_SUM_W:0]   sum_ext;
    logic [ERR_SUM_W-1:0] err_sum_q;
    logic [W:0]           err_max_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Exact reference travels alongside o_q so the error is known at output.
    always_ff @(posedge CLK) begin
        if (RST)
            exact_q <= '0;
        else if (s2_adv && vld_pipe[1])
            exact_q <= {1'b0, s1_q.a} + {1'b0, s1_q.b};
    end

    assign out_hs  = vld_pipe[2] && OUT_READY;
    assign err     = (o_q >= exact_q) ? (o_q - exact_q) : (exact_q - o_q);
    assign sum_ext = {1'b0, err_sum_q} + (ERR_SUM_W+1)'(err);

    always_ff @(posedge CLK) begin
        if (RST || ERR_CLR) begin
            err_sum_q <= '0;
            err_max_q <= '0;
            err_cnt_q <= '0;
        end else if (out_hs) begin
            err_sum_q <= sum_ext[ERR_SUM_W] ? ERR_SUM_SAT : sum_ext[ERR_SUM_W-1:0];
            if (err > err_max_q)
                err_max_q <= err;
            if (err != '0 && err_cnt_q != ERR_CNT_SAT)
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign ERR_SUM = err_sum_q;
    assign ERR_MAX = err_max_q;
    assign ERR_CNT = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = ERR_CLR;
    assign ERR_SUM = '0;
    assign ERR_MAX = '0;
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// tb_approx_add_pipe -- directed self-checking bench for approx_add_pipe
// (W=8, K=4). Statistic expectations collapse to 0 when the monitor macro
// APPROX_ERR_MON_EN is not defined.
module tb_approx_add_pipe;

    localparam int W = 8;
    localparam int K = 4;
`ifdef APPROX_ERR_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         MODE = 1'b0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b1;
    logic [W:0]   O;
    logic         ERR_CLR = 1'b0;
    logic [31:0]  ERR_SUM;
    logic [W:0]   ERR_MAX;
    logic [15:0]  ERR_CNT;

    int checks = 0;
    int errors = 0;

    // Running expected statistics (before MON masking).
    logic [31:0] es = '0;
    logic [W:0]  em = '0;
    logic [15:0] ec = '0;

    always #5 CLK = ~CLK;

    approx_add_pipe #(.W(W), .K(K)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .MODE(MODE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .O(O), .ERR_CLR(ERR_CLR), .ERR_SUM(ERR_SUM), .ERR_MAX(ERR_MAX),
        .ERR_CNT(ERR_CNT)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Reference for the streaming test, written arithmetically.
    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic m);
        int hi;
        if (!m) return 9'(int'(a) + int'(b));
        hi = int'(a >> 4) + int'(b >> 4) + ((a[3] && b[3]) ? 1 : 0);
        return 9'(hi * 16 + int'(a[3:0] | b[3:0]));
    endfunction

    task automatic test_reset;
        RST = 1'b1;
        tick();
        tick();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
        checks++; if (O !== 9'h000) begin errors++; $display("FAIL reset_o got %h want 000", O); end
        checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", IN_READY); end
        checks++; if (ERR_SUM !== 32'd0 || ERR_MAX !== 9'd0 || ERR_CNT !== 16'd0) begin
            errors++; $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", ERR_SUM, ERR_MAX, ERR_CNT); end
        RST = 1'b0;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", IN_READY); end
    endtask

    task automatic test_approx;
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; A = 8'h0F; B = 8'h01; MODE = 1'b1;
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL approx_lat1 got %b want 0", OUT_VALID); end
        tick();
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL approx_lat2 got %b want 1", OUT_VALID); end
        checks++; if (O !== 9'h00F) begin errors++; $display("FAIL approx_o got %h want 00f", O); end
        tick();
        es = 32'd1; em = 9'd1; ec = 16'd1;
        checks++; if (ERR_SUM !== (MON ? es : 32'd0)) begin errors++; $display("FAIL approx_err_sum got %0d want %0d", ERR_SUM, MON ? es : 32'd0); end
        checks++; if (ERR_CNT !== (MON ? ec : 16'd0)) begin errors++; $display("FAIL approx_err_cnt got %0d want %0d", ERR_CNT, MON ? ec : 16'd0); end
        checks++; if (ERR_MAX !== (MON ? em : 9'd0)) begin errors++; $display("FAIL approx_err_max got %0d want %0d", ERR_MAX, MON ? em : 9'd0); end
    endtask

    task automatic test_err_max;
        IN_VALID = 1'b1; A = 8'h88; B = 8'h88; MODE = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        checks++; if (O !== 9'h118) begin errors++; $display("FAIL errmax_approx_o got %h want 118", O); end
        tick();
        es = 32'd9; em = 9'd8; ec = 16'd2;
        checks++; if (ERR_MAX !== (MON ? em : 9'd0)) begin errors++; $display("FAIL errmax_max got %0d want %0d", ERR_MAX, MON ? em : 9'd0); end
        checks++; if (ERR_SUM !== (MON ? es : 32'd0)) begin errors++; $display("FAIL errmax_sum got %0d want %0d", ERR_SUM, MON ? es : 32'd0); end
        IN_VALID = 1'b1; MODE = 1'b0;
        tick();
        IN_VALID = 1'b0;
        tick();
        checks++; if (O !== 9'h110) begin errors++; $display("FAIL errmax_exact_o got %h want 110", O); end
        tick();
        checks++; if (ERR_SUM !== (MON ? es : 32'd0) || ERR_MAX !== (MON ? em : 9'd0) || ERR_CNT !== (MON ? ec : 16'd0)) begin
            errors++; $display("FAIL errmax_exact_stats got %0d/%0d/%0d want %0d/%0d/%0d",
                               ERR_SUM, ERR_MAX, ERR_CNT, MON ? es : 32'd0, MON ? em : 9'd0, MON ? ec : 16'd0); end
    endtask

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic [8:0] o;
        logic [8:0] err;
    } vec_t;

    task automatic test_vectors;
        vec_t vt [9];
        vt[0] = '{8'h00, 8'h00, 1'b0, 9'h000, 9'd0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 9'h100, 9'd0};
        vt[2] = '{8'h7F, 8'h80, 1'b0, 9'h0FF, 9'd0};
        vt[3] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 9'd1};
        vt[4] = '{8'h33, 8'h44, 1'b1, 9'h077, 9'd0};
        vt[5] = '{8'h05, 8'h03, 1'b1, 9'h007, 9'd1};
        vt[6] = '{8'h80, 8'h80, 1'b1, 9'h100, 9'd0};
        vt[7] = '{8'h0C, 8'h0C, 1'b1, 9'h01C, 9'd4};
        vt[8] = '{8'hF0, 8'h0F, 1'b0, 9'h0FF, 9'd0};
        OUT_READY = 1'b1;
        for (int i = 0; i < 9; i++) begin
            IN_VALID = 1'b1; A = vt[i].a; B = vt[i].b; MODE = vt[i].m;
            tick();
            IN_VALID = 1'b0;
            tick();
            checks++; if (OUT_VALID !== 1'b1 || O !== vt[i].o) begin
                errors++; $display("FAIL vec%0d_o got v=%b o=%h want v=1 o=%h", i, OUT_VALID, O, vt[i].o); end
            tick();
            es = es + 32'(vt[i].err);
            if (vt[i].err > em) em = vt[i].err;
            if (vt[i].err != 0) ec = ec + 16'd1;
            checks++; if (ERR_SUM !== (MON ? es : 32'd0) || ERR_MAX !== (MON ? em : 9'd0) || ERR_CNT !== (MON ? ec : 16'd0)) begin
                errors++; $display("FAIL vec%0d_stats got %0d/%0d/%0d want %0d/%0d/%0d", i,
                                   ERR_SUM, ERR_MAX, ERR_CNT, MON ? es : 32'd0, MON ? em : 9'd0, MON ? ec : 16'd0); end
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp_q [$];
        logic [8:0] prev_o;
        logic [8:0] want;
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic [3:0] pat;
        bit         prev_stall;
        bit         acc;
        bit         hs;
        int         tx;
        int         rx;
        int         cyc;
        int         occ;
        pat = 4'b1001;    // OUT_READY sequence 1,0,0,1 repeating
        prev_stall = 1'b0;
        prev_o = '0;
        tx = 0; rx = 0; cyc = 0;
        a = '0; b = '0; m = 1'b0;
        while (rx < 16 && cyc < 200) begin
            OUT_READY = pat[cyc % 4];
            if (tx < 16) begin
                a = 8'(tx * 17); b = 8'(tx + 3); m = tx[0];
                IN_VALID = 1'b1; A = a; B = b; MODE = m;
            end else begin
                IN_VALID = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++; if (OUT_VALID !== 1'b1 || O !== prev_o) begin
                    errors++; $display("FAIL b2b_stall_hold cyc%0d got v=%b o=%h want v=1 o=%h", cyc, OUT_VALID, O, prev_o); end
            end
            occ = tx - rx;
            checks++; if (IN_READY !== !(occ == 2 && !OUT_READY)) begin
                errors++; $display("FAIL b2b_in_ready cyc%0d got %b want %b", cyc, IN_READY, !(occ == 2 && !OUT_READY)); end
            acc = IN_VALID && IN_READY;
            hs  = OUT_VALID && OUT_READY;
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_output cyc%0d got o=%h want none", cyc, O);
                end else begin
                    want = exp_q.pop_front();
                    if (O !== want) begin errors++; $display("FAIL b2b_order rx%0d got %h want %h", rx, O, want); end
                end
                rx++;
            end
            if (acc) begin
                exp_q.push_back(ref_sum(a, b, m));
                tx++;
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_o = O;
            tick();
            cyc++;
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        checks++; if (rx != 16 || tx != 16) begin
            errors++; $display("FAIL b2b_count got tx=%0d rx=%0d want 16/16", tx, rx); end
    endtask

    task automatic test_reset_inflight;
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; A = 8'h01; B = 8'h02; MODE = 1'b0;
        tick();
        A = 8'h03; B = 8'h04;
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b1 || O !== 9'h003 || IN_READY !== 1'b0) begin
            errors++; $display("FAIL full_state got v=%b o=%h rdy=%b want 1/003/0", OUT_VALID, O, IN_READY); end
        RST = 1'b1;
        tick();
        es = '0; em = '0; ec = '0;
        checks++; if (OUT_VALID !== 1'b0 || O !== 9'h000) begin
            errors++; $display("FAIL rst_flush got v=%b o=%h want 0/000", OUT_VALID, O); end
        checks++; if (ERR_SUM !== 32'd0 || ERR_MAX !== 9'd0 || ERR_CNT !== 16'd0) begin
            errors++; $display("FAIL rst_stats got %0d/%0d/%0d want 0/0/0", ERR_SUM, ERR_MAX, ERR_CNT); end
        RST = 1'b0;
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; A = 8'h10; B = 8'h20; MODE = 1'b0;
        tick();
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_first_lat1 got %b want 0", OUT_VALID); end
        tick();
        checks++; if (OUT_VALID !== 1'b1 || O !== 9'h030) begin
            errors++; $display("FAIL rst_first_out got v=%b o=%h want 1/030", OUT_VALID, O); end
        tick();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_no_ghost got %b want 0", OUT_VALID); end
    endtask

    task automatic test_err_clr;
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; A = 8'h05; B = 8'h03; MODE = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        checks++; if (ERR_SUM !== (MON ? 32'd1 : 32'd0)) begin
            errors++; $display("FAIL clr_pre_sum got %0d want %0d", ERR_SUM, MON ? 32'd1 : 32'd0); end
        IN_VALID = 1'b1; A = 8'h88; B = 8'h88; MODE = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL clr_out_valid got %b want 1", OUT_VALID); end
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        checks++; if (ERR_SUM !== 32'd0 || ERR_MAX !== 9'd0 || ERR_CNT !== 16'd0) begin
            errors++; $display("FAIL clr_wins got %0d/%0d/%0d want 0/0/0", ERR_SUM, ERR_MAX, ERR_CNT); end
    endtask

    initial begin
        test_reset();
        test_approx();
        test_err_max();
        test_vectors();
        test_back_to_back();
        test_reset_inflight();
        test_err_clr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
